// File: rtl/fetch_queue_pkg.sv
// Shared fetch-path definitions: default address/data widths, reset vector and queue depth.
package fetch_queue_pkg;
    localparam int CPU_ADDR_W = 16;
    localparam int CPU_DATA_W = 16;
    localparam logic [CPU_ADDR_W-1:0] CPU_RESET_PC = '0;
    localparam int FQ_DEPTH = 4;
endpackage

// File: rtl/fetch_queue_sync_fifo.sv
// Synchronous FIFO with flush; head reads as zero when empty, full/empty told apart by count.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_pop;

    assign do_pop = pop & (count != '0);
    assign head   = (count != '0) ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push && !do_pop)
                count <= count + CW'(1);
            else if (!push && do_pop)
                count <= count - CW'(1);
        end
    end

    // Storage carries no reset; validity is tracked entirely by count.
    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: credit-based issue to a 1-cycle memory, redirect flush and halt.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int                 ADDR_W   = CPU_ADDR_W,
    parameter int                 DATA_W   = CPU_DATA_W,
    parameter int                 DEPTH    = FQ_DEPTH,
    parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(CPU_RESET_PC)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       redirect,
    input  logic [ADDR_W-1:0]          redirect_pc,
    input  logic                       halt,
    output logic                       mem_ren,
    output logic [ADDR_W-1:0]          mem_addr,
    input  logic [DATA_W-1:0]          mem_data,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_instr,
    output logic [ADDR_W-1:0]          out_pc,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = ADDR_W + DATA_W;

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] inflight_pc;
    logic              inflight;
    logic              credit_ok;
    logic              issue;
    logic              push;
    logic              pop;
    logic [EW-1:0]     head;
    logic [CW-1:0]     occ;

    // Stored entries plus the outstanding read must fit, so a push never meets a full queue.
    assign credit_ok = (int'(occ) + int'(inflight)) < DEPTH;
    assign issue     = rst_n & credit_ok & ~halt & ~redirect;
    assign push      = inflight & ~redirect;
    assign out_valid = (occ != '0) & ~halt;
    assign pop       = out_valid & out_ready & ~redirect;

    assign mem_ren   = issue;
    assign mem_addr  = fetch_pc;
    assign out_pc    = head[EW-1:DATA_W];
    assign out_instr = head[DATA_W-1:0];
    assign count     = occ;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= RESET_PC;
        end else begin
            inflight <= issue;
            if (issue)
                inflight_pc <= fetch_pc;
            if (redirect)
                fetch_pc <= redirect_pc;
            else if (issue)
                fetch_pc <= fetch_pc + ADDR_W'(1);
        end
    end

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect),
        .push      (push),
        .push_data ({inflight_pc, mem_data}),
        .pop       (pop),
        .head      (head),
        .count     (occ)
    );
endmodule
